// File: rtl/mvu_ctrl_pkg.sv
// MVU controller shared types: FSM state encoding and default widths.
// Optional stall counter enabled by MVU_CTRL_PERF_EN (see mvu_ctrl).
package mvu_ctrl_pkg;

  localparam int DEF_BWBANKA  = 9;
  localparam int DEF_BDBANKA  = 14;
  localparam int DEF_BPREC    = 4;
  localparam int DEF_BLEN     = 9;
  localparam int DEF_PIPE_LAT = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = S_IDLE,
    ISSUE = S_ISSUE,
    DRAIN = S_DRAIN,
    WRITE = S_WRITE
  } state_t;

endpackage

// File: rtl/mvu_ctrl_agu.sv
// MVU controller address generator: latched job config, k/b/o loop
// counters and the wrap-around read/write address arithmetic.
module mvu_ctrl_agu
  import mvu_ctrl_pkg::*;
#(
  parameter int BWBANKA = DEF_BWBANKA,
  parameter int BDBANKA = DEF_BDBANKA,
  parameter int BPREC   = DEF_BPREC,
  parameter int BLEN    = DEF_BLEN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               next_out,
  input  logic [BPREC-1:0]   iprec,
  input  logic [BLEN-1:0]    len,
  input  logic [BLEN-1:0]    nout,
  input  logic [BWBANKA-1:0] wbase,
  input  logic [BDBANKA-1:0] ibase,
  input  logic [BDBANKA-1:0] obase,
  output logic               k_zero,
  output logic               k_last,
  output logic               b_top,
  output logic               b_last,
  output logic               o_last,
  output logic [BDBANKA-1:0] rdd_addr,
  output logic [BWBANKA-1:0] rdw_addr,
  output logic [BDBANKA-1:0] wrd_addr
);

  logic [BPREC-1:0]   iprec_q;
  logic [BLEN-1:0]    len_q;
  logic [BLEN-1:0]    nout_q;
  logic [BWBANKA-1:0] wbase_q;
  logic [BDBANKA-1:0] ibase_q;
  logic [BDBANKA-1:0] obase_q;
  logic [BLEN-1:0]    k;
  logic [BPREC-1:0]   b;
  logic [BLEN-1:0]    o;

  logic [BPREC+BLEN-1:0] prod_b;
  logic [2*BLEN-1:0]     prod_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      iprec_q <= '0;
      len_q   <= '0;
      nout_q  <= '0;
      wbase_q <= '0;
      ibase_q <= '0;
      obase_q <= '0;
      k       <= '0;
      b       <= '0;
      o       <= '0;
    end else if (load) begin
      iprec_q <= iprec;
      len_q   <= len;
      nout_q  <= nout;
      wbase_q <= wbase;
      ibase_q <= ibase;
      obase_q <= obase;
      k       <= '0;
      b       <= iprec - BPREC'(1);
      o       <= '0;
    end else if (next_out) begin
      o <= o + BLEN'(1);
      b <= iprec_q - BPREC'(1);
      k <= '0;
    end else if (step) begin
      if (k_last) begin
        k <= '0;
        if (!b_last)
          b <= b - BPREC'(1);
      end else begin
        k <= k + BLEN'(1);
      end
    end
  end

  assign k_zero = (k == '0);
  assign k_last = (k == len_q - BLEN'(1));
  assign b_top  = (b == iprec_q - BPREC'(1));
  assign b_last = (b == '0);
  assign o_last = (o == nout_q - BLEN'(1));

  // Products are taken at full width; truncation gives the bank wrap.
  assign prod_b = (BPREC+BLEN)'(b) * (BPREC+BLEN)'(len_q);
  assign prod_o = (2*BLEN)'(o) * (2*BLEN)'(len_q);

  assign rdd_addr = ibase_q + BDBANKA'(prod_b) + BDBANKA'(k);
  assign rdw_addr = wbase_q + BWBANKA'(prod_o) + BWBANKA'(k);
  assign wrd_addr = obase_q + BDBANKA'(o);

endmodule

// File: rtl/mvu_ctrl.sv
// MVU job controller: IDLE/ISSUE/DRAIN/WRITE sequencer over mvu_ctrl_agu.
// Define MVU_CTRL_PERF_EN to add the perf_stall read-stall counter.
module mvu_ctrl
  import mvu_ctrl_pkg::*;
#(
  parameter int BWBANKA  = DEF_BWBANKA,
  parameter int BDBANKA  = DEF_BDBANKA,
  parameter int BPREC    = DEF_BPREC,
  parameter int BLEN     = DEF_BLEN,
  parameter int PIPE_LAT = DEF_PIPE_LAT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [BPREC-1:0]   iprec,
  input  logic [BLEN-1:0]    len,
  input  logic [BLEN-1:0]    nout,
  input  logic [BWBANKA-1:0] wbase,
  input  logic [BDBANKA-1:0] ibase,
  input  logic [BDBANKA-1:0] obase,
  output logic               busy,
  output logic               done,
  output logic               rdd_en,
  input  logic               rdd_grnt,
  output logic [BDBANKA-1:0] rdd_addr,
  output logic [BWBANKA-1:0] rdw_addr,
  output logic               acc_clr,
  output logic               acc_sh,
  output logic               wrd_en,
  input  logic               wrd_grnt,
  output logic [BDBANKA-1:0] wrd_addr
`ifdef MVU_CTRL_PERF_EN
  ,
  output logic [31:0]        perf_stall
`endif
);

  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  state_t        state;
  state_t        nxt;
  logic [DW-1:0] dcnt;
  logic          done_q;

  logic issue, write;
  logic accept, degen, go;
  logic step, wgrant, last_rd;
  logic k_zero, k_last, b_top, b_last, o_last;

  logic [BDBANKA-1:0] agu_rdd;
  logic [BWBANKA-1:0] agu_rdw;
  logic [BDBANKA-1:0] agu_wrd;

  assign issue   = (state == ISSUE);
  assign write   = (state == WRITE);
  assign accept  = (state == IDLE) && start;
  assign degen   = (iprec == '0) || (len == '0) || (nout == '0);
  assign go      = accept && !degen;
  assign step    = issue && rdd_grnt;
  assign wgrant  = write && wrd_grnt;
  assign last_rd = step && k_last && b_last;

  mvu_ctrl_agu #(
    .BWBANKA (BWBANKA),
    .BDBANKA (BDBANKA),
    .BPREC   (BPREC),
    .BLEN    (BLEN)
  ) u_agu (
    .clk      (clk),
    .rst      (rst),
    .load     (go),
    .step     (step),
    .next_out (wgrant && !o_last),
    .iprec    (iprec),
    .len      (len),
    .nout     (nout),
    .wbase    (wbase),
    .ibase    (ibase),
    .obase    (obase),
    .k_zero   (k_zero),
    .k_last   (k_last),
    .b_top    (b_top),
    .b_last   (b_last),
    .o_last   (o_last),
    .rdd_addr (agu_rdd),
    .rdw_addr (agu_rdw),
    .wrd_addr (agu_wrd)
  );

  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (go)
          nxt = ISSUE;
      end
      ISSUE: begin
        if (last_rd) begin
          if (PIPE_LAT == 0)
            nxt = WRITE;
          else
            nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (dcnt == DW'(PIPE_LAT - 1))
          nxt = WRITE;
      end
      WRITE: begin
        if (wgrant) begin
          if (o_last)
            nxt = IDLE;
          else
            nxt = ISSUE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      dcnt   <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= nxt;
      dcnt   <= (state == DRAIN) ? dcnt + DW'(1) : '0;
      done_q <= (accept && degen) || (wgrant && o_last);
    end
  end

  // Outputs are forced low while rst is high, even mid-job.
  assign busy     = !rst && (state != IDLE);
  assign done     = !rst && done_q;
  assign rdd_en   = !rst && issue;
  assign rdd_addr = rdd_en ? agu_rdd : '0;
  assign rdw_addr = rdd_en ? agu_rdw : '0;
  assign acc_clr  = rdd_en && rdd_grnt && k_zero && b_top;
  assign acc_sh   = rdd_en && rdd_grnt && k_zero && !b_top;
  assign wrd_en   = !rst && write;
  assign wrd_addr = wrd_en ? agu_wrd : '0;

`ifdef MVU_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst || accept)
      perf_stall <= '0;
    else if (issue && !rdd_grnt && perf_stall != '1)
      perf_stall <= perf_stall + 32'd1;
  end
`endif

endmodule

// File: tb/tb_mvu_ctrl.sv
// Self-checking bench for mvu_ctrl: loop-nest reference model,
// per-cycle compare process, directed cases and randomized jobs.
module tb_mvu_ctrl;

  localparam int PL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  iprec;
  logic [8:0]  len;
  logic [8:0]  nout;
  logic [8:0]  wbase;
  logic [13:0] ibase;
  logic [13:0] obase;
  logic        busy, done, rdd_en, rdd_grnt;
  logic [13:0] rdd_addr;
  logic [8:0]  rdw_addr;
  logic        acc_clr, acc_sh, wrd_en, wrd_grnt;
  logic [13:0] wrd_addr;
`ifdef MVU_CTRL_PERF_EN
  logic [31:0] perf_stall;
`endif

  mvu_ctrl #(.PIPE_LAT(PL)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .iprec    (iprec),
    .len      (len),
    .nout     (nout),
    .wbase    (wbase),
    .ibase    (ibase),
    .obase    (obase),
    .busy     (busy),
    .done     (done),
    .rdd_en   (rdd_en),
    .rdd_grnt (rdd_grnt),
    .rdd_addr (rdd_addr),
    .rdw_addr (rdw_addr),
    .acc_clr  (acc_clr),
    .acc_sh   (acc_sh),
    .wrd_en   (wrd_en),
    .wrd_grnt (wrd_grnt),
    .wrd_addr (wrd_addr)
`ifdef MVU_CTRL_PERF_EN
    ,
    .perf_stall (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int rdd;
    int rdw;
    bit clr;
    bit sh;
    bit last;
  } rd_t;

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  rd_t rq[$];
  int  wq[$];
  int  log_rdd[$], log_rdw[$], log_clr[$], log_sh[$], log_wr[$];
  bit  job_active = 0, rd_active = 0, wr_pend = 0, post_rst = 0;
  int  wr_at = 0, done_due = -10, done_cnt = 0;
  longint stall_m = 0;
  bit  rand_mode = 0, wr_hold = 0;
  int  stall_from = -100;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, longint got, longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d cyc %0d", nm, got, exp, cyc);
    end
  endfunction

  // Reference: plain loop nest over outputs, bit-planes (MSB first), tiles.
  function automatic void build(int ip, int ln, int no,
                                int wb, int ib, int ob);
    rd_t e;
    for (int o = 0; o < no; o++) begin
      for (int b = ip - 1; b >= 0; b--) begin
        for (int k = 0; k < ln; k++) begin
          e.rdd  = (ib + b * ln + k) % 16384;
          e.rdw  = (wb + o * ln + k) % 512;
          e.clr  = (b == ip - 1) && (k == 0);
          e.sh   = (k == 0) && (b != ip - 1);
          e.last = (b == 0) && (k == ln - 1);
          rq.push_back(e);
        end
      end
      wq.push_back((ob + o) % 16384);
    end
  endfunction

  task automatic chk_zero(string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rdd_en"}, rdd_en, 0);
    chk({tag, "_rdd_addr"}, rdd_addr, 0);
    chk({tag, "_rdw_addr"}, rdw_addr, 0);
    chk({tag, "_acc_clr"}, acc_clr, 0);
    chk({tag, "_acc_sh"}, acc_sh, 0);
    chk({tag, "_wrd_en"}, wrd_en, 0);
    chk({tag, "_wrd_addr"}, wrd_addr, 0);
  endtask

  always @(negedge clk) begin
    bit  was_act;
    rd_t e;
    if (rst) begin
      chk_zero("in_rst");
      post_rst = 1;
      job_active = 0;
      rd_active = 0;
      wr_pend = 0;
      rq.delete();
      wq.delete();
      done_due = -10;
      stall_m = 0;
    end else begin
      if (post_rst) chk_zero("post_rst");
      post_rst = 0;
      was_act = job_active;
      if (done) done_cnt++;
      chk("busy", busy, job_active);
      chk("done", done, cyc == done_due);
      chk("rdd_en", rdd_en, rd_active);
      chk("wrd_en", wrd_en, wr_pend && cyc >= wr_at);
`ifdef MVU_CTRL_PERF_EN
      chk("perf_stall", perf_stall, stall_m);
      if (rd_active && !rdd_grnt) stall_m++;
`endif
      if (rd_active && rq.size() > 0) begin
        e = rq[0];
        chk("rdd_addr", rdd_addr, e.rdd);
        chk("rdw_addr", rdw_addr, e.rdw);
        if (rdd_grnt) begin
          chk("acc_clr", acc_clr, e.clr);
          chk("acc_sh", acc_sh, e.sh);
          if (acc_clr) log_clr.push_back(log_rdd.size());
          if (acc_sh) log_sh.push_back(log_rdd.size());
          log_rdd.push_back(rdd_addr);
          log_rdw.push_back(rdw_addr);
          void'(rq.pop_front());
          if (e.last) begin
            rd_active = 0;
            wr_pend = 1;
            wr_at = cyc + PL + 1;
          end
        end else begin
          chk("stall_clr", acc_clr, 0);
          chk("stall_sh", acc_sh, 0);
        end
      end else begin
        chk("idle_clr", acc_clr, 0);
        chk("idle_sh", acc_sh, 0);
      end
      if (wr_pend && cyc >= wr_at && wrd_en) begin
        chk("wrd_addr", wrd_addr, wq[0]);
        if (wrd_grnt) begin
          log_wr.push_back(wrd_addr);
          void'(wq.pop_front());
          wr_pend = 0;
          if (wq.size() == 0) begin
            job_active = 0;
            done_due = cyc + 1;
          end else begin
            rd_active = 1;
          end
        end
      end
      if (start && !was_act) begin
        stall_m = 0;
        if (iprec == 0 || len == 0 || nout == 0) begin
          done_due = cyc + 1;
        end else begin
          build(iprec, len, nout, wbase, ibase, obase);
          job_active = 1;
          rd_active = 1;
        end
      end
    end
  end

  initial begin
    rdd_grnt = 1'b1;
    wrd_grnt = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (cyc >= stall_from && cyc < stall_from + 3)
        rdd_grnt = 1'b0;
      else
        rdd_grnt = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (wr_hold)
        wrd_grnt = 1'b0;
      else
        wrd_grnt = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic clear_logs();
    log_rdd.delete();
    log_rdw.delete();
    log_clr.delete();
    log_sh.delete();
    log_wr.delete();
  endtask

  task automatic start_job(int ip, int ln, int no, int wb, int ib,
                           int ob, bit spur, bit stall);
    @(posedge clk);
    #1;
    iprec = 4'(ip);
    len = 9'(ln);
    nout = 9'(no);
    wbase = 9'(wb);
    ibase = 14'(ib);
    obase = 14'(ob);
    start = 1'b1;
    if (stall) stall_from = cyc + 3;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (spur) begin
      iprec = 4'($urandom_range(1, 3));
      len = 9'($urandom_range(1, 4));
      ibase = 14'($urandom);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
  endtask

  task automatic wait_job(string nm);
    bit ok = 0;
    for (int n = 0; n < 4000 && !ok; n++) begin
      @(negedge clk);
      #1;
      if (!job_active && cyc > done_due) ok = 1;
    end
    chk({nm, "_finished"}, ok, 1);
  endtask

  task automatic do_job(string nm, int ip, int ln, int no, int wb,
                        int ib, int ob, bit spur, bit stall);
    clear_logs();
    start_job(ip, ln, no, wb, ib, ob, spur, stall);
    wait_job(nm);
  endtask

  task automatic pulse_rst();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic chk_basic(string nm);
    int ex_rdd[6] = '{103, 104, 105, 100, 101, 102};
    int ex_rdw[6] = '{10, 11, 12, 10, 11, 12};
    chk({nm, "_nreads"}, log_rdd.size(), 6);
    for (int i = 0; i < 6 && i < log_rdd.size(); i++) begin
      chk({nm, "_rdd"}, log_rdd[i], ex_rdd[i]);
      chk({nm, "_rdw"}, log_rdw[i], ex_rdw[i]);
    end
    chk({nm, "_nclr"}, log_clr.size(), 1);
    chk({nm, "_nsh"}, log_sh.size(), 1);
    if (log_clr.size() == 1) chk({nm, "_clr_at"}, log_clr[0], 0);
    if (log_sh.size() == 1) chk({nm, "_sh_at"}, log_sh[0], 3);
    chk({nm, "_nwr"}, log_wr.size(), 1);
    if (log_wr.size() == 1) chk({nm, "_wr"}, log_wr[0], 500);
  endtask

  initial begin
    int dc;
    bit seen;
    rst = 1'b1;
    start = 1'b0;
    iprec = '0;
    len = '0;
    nout = '0;
    wbase = '0;
    ibase = '0;
    obase = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    build(2, 3, 1, 10, 100, 500);
    chk("model_rdd0", rq[0].rdd, 103);
    chk("model_rdd3", rq[3].rdd, 100);
    chk("model_rdw3", rq[3].rdw, 10);
    chk("model_sh3", rq[3].sh, 1);
    chk("model_wr", wq[0], 500);
    rq.delete();
    wq.delete();
    build(1, 2, 1, 0, 16383, 0);
    chk("model_wrap", rq[1].rdd, 0);
    rq.delete();
    wq.delete();

    dc = done_cnt;
    do_job("basic", 2, 3, 1, 10, 100, 500, 0, 0);
    chk_basic("basic");
    chk("basic_done_once", done_cnt - dc, 1);

    dc = done_cnt;
    do_job("stall", 2, 3, 1, 10, 100, 500, 1, 1);
    stall_from = -100;
    chk_basic("stall");
    chk("stall_done_once", done_cnt - dc, 1);
`ifdef MVU_CTRL_PERF_EN
    chk("stall_perf", perf_stall, 3);
`endif

    dc = done_cnt;
    do_job("multi", 1, 2, 2, 10, 40, 200, 0, 0);
    chk("multi_nrdw", log_rdw.size(), 4);
    if (log_rdw.size() == 4) begin
      chk("multi_rdw2", log_rdw[2], 12);
      chk("multi_rdw3", log_rdw[3], 13);
    end
    chk("multi_nwr", log_wr.size(), 2);
    if (log_wr.size() == 2) chk("multi_wr1", log_wr[1], 201);
    chk("multi_done_once", done_cnt - dc, 1);

    dc = done_cnt;
    do_job("degen_len", 2, 0, 1, 1, 2, 3, 0, 0);
    chk("degen_len_reads", log_rdd.size(), 0);
    chk("degen_len_done", done_cnt - dc, 1);
    do_job("degen_prec", 0, 3, 1, 1, 2, 3, 0, 0);
    do_job("degen_nout", 2, 3, 0, 1, 2, 3, 0, 0);
    chk("degen_reads", log_rdd.size(), 0);

    do_job("wrap", 1, 2, 1, 0, 16383, 0, 0, 0);
    chk("wrap_n", log_rdd.size(), 2);
    if (log_rdd.size() == 2) begin
      chk("wrap_rdd0", log_rdd[0], 16383);
      chk("wrap_rdd1", log_rdd[1], 0);
    end

    clear_logs();
    start_job(4, 4, 2, 7, 9, 11, 0, 0);
    repeat (5) @(posedge clk);
    pulse_rst();
    repeat (2) @(posedge clk);
    dc = done_cnt;
    do_job("after_rst1", 2, 3, 1, 10, 100, 500, 0, 0);
    chk_basic("after_rst1");
    chk("after_rst1_done", done_cnt - dc, 1);

    wr_hold = 1;
    clear_logs();
    start_job(1, 1, 1, 0, 0, 77, 0, 0);
    seen = 0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      if (wrd_en) seen = 1;
    end
    chk("write_reached", seen, 1);
    repeat (3) @(posedge clk);
    pulse_rst();
    wr_hold = 0;
    dc = done_cnt;
    do_job("after_rst2", 2, 3, 1, 10, 100, 500, 0, 0);
    chk_basic("after_rst2");
    chk("after_rst2_done", done_cnt - dc, 1);

    rand_mode = 1;
    for (int j = 0; j < 40; j++) begin
      int ip, ln, no;
      ip = $urandom_range(0, 3);
      ln = $urandom_range(0, 4);
      no = $urandom_range(0, 3);
      dc = done_cnt;
      do_job("rand", ip, ln, no, $urandom_range(0, 511),
             $urandom_range(16370, 16383), $urandom_range(0, 16383),
             (ip != 0 && ln != 0 && no != 0) && j[0], 0);
      chk("rand_done_once", done_cnt - dc, 1);
      chk("rand_nreads", log_rdd.size(), ip * ln * no);
      chk("rand_nwr", log_wr.size(), (ip * ln == 0) ? 0 : no);
    end
    rand_mode = 0;

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
